// File: rtl/data_memory_stage.sv
// Memory-access stage: word-addressed data memory behind a valid/ready request and one-cycle response pulse.
// Define DATA_MEMORY_STAGE_STATS_EN to add load/store/fault event counters.
module data_memory_stage #(
   parameter int DEPTH = 256,
   parameter int LAT   = 2,
   parameter int ID_LW = 13,
   parameter int ID_SW = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] instr_id,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        fault,
   output logic        busy
`ifdef DATA_MEMORY_STAGE_STATS_EN
   ,
   output logic [15:0] load_count,
   output logic [15:0] store_count,
   output logic [15:0] fault_count
`endif
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
   localparam logic [31:0] LW_W    = 32'(ID_LW);
   localparam logic [31:0] SW_W    = 32'(ID_SW);
   localparam logic [3:0]  LAT_W   = 4'(LAT);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept;
   logic        do_access;
   logic        ld_ok, st_ok, flt;
   logic [31:0] id_p0, addr_p0, wdata_p0;
   logic [AW-1:0] aidx;
   logic [31:0] mem [DEPTH];

   assign req_ready  = (state == IDLE);
   assign busy       = !req_ready;
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;
   assign do_access  = (state == WAIT) && (cnt == 4'd0);
   assign aidx       = addr_p0[AW-1:0];

   // Request classification, evaluated against the latched request on the access edge
   assign ld_ok = do_access && (id_p0 == LW_W) && (addr_p0 < DEPTH_W);
   assign st_ok = do_access && (id_p0 == SW_W) && (addr_p0 < DEPTH_W);
   assign flt   = do_access && !ld_ok && !st_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: if (accept) begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_W;
         end
         WAIT: if (cnt == 4'd0) state_nxt = RESP;
               else             cnt_nxt   = cnt - 4'd1;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture: data only, qualified by the FSM so no reset needed
   always_ff @(posedge clk) begin
      if (accept) begin
         id_p0    <= instr_id;
         addr_p0  <= addr;
         wdata_p0 <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
      end else if (st_ok) begin
         mem[aidx] <= wdata_p0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= 32'd0;
         fault <= 1'b0;
      end else if (do_access) begin
         fault <= flt;
         if (ld_ok) rdata <= mem[aidx];
      end
   end

`ifdef DATA_MEMORY_STAGE_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_count  <= 16'd0;
         store_count <= 16'd0;
         fault_count <= 16'd0;
      end else begin
         if (ld_ok) load_count  <= load_count + 16'd1;
         if (st_ok) store_count <= store_count + 16'd1;
         if (flt)   fault_count <= fault_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed testbench for data_memory_stage with hand-computed expectations (LAT=2, DEPTH=256).
module tb_data_memory_stage;

   localparam int LAT   = 2;
   localparam int DEPTH = 256;
   localparam logic [31:0] LW = 32'd13;
   localparam logic [31:0] SW = 32'd14;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] instr_id = 32'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        fault;
   logic        busy;
`ifdef DATA_MEMORY_STAGE_STATS_EN
   logic [15:0] load_count, store_count, fault_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   data_memory_stage #(.DEPTH(DEPTH), .LAT(LAT), .ID_LW(13), .ID_SW(14)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .instr_id(instr_id), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
      .rdata(rdata), .fault(fault), .busy(busy)
`ifdef DATA_MEMORY_STAGE_STATS_EN
      , .load_count(load_count), .store_count(store_count), .fault_count(fault_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [31:0] id, input logic [31:0] a, input logic [31:0] d);
      int g = 0;
      @(negedge clk);
      while (!req_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b1;
      instr_id  = id;
      addr      = a;
      wdata     = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag, output logic [31:0] rd, output logic ft);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!resp_valid && n < 20);
      chk({tag, "_lat"}, n, LAT + 1);
      rd = rdata;
      ft = fault;
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
   endtask

   task automatic access(input string tag, input logic [31:0] id, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_ft);
      logic [31:0] rd;
      logic        ft;
      issue(id, a, d);
      wait_resp(tag, rd, ft);
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_fault"}, {31'd0, ft}, {31'd0, exp_ft});
   endtask

   initial begin
      int low;
      int resp_seen;
      logic [31:0] rd;
      logic        ft;
`ifdef DATA_MEMORY_STAGE_STATS_EN
      logic [15:0] l0, s0, f0;
`endif

      // reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_resp", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      access("lw5", LW, 32'd5, 32'd0, 32'd0, 1'b0);

      // store then load
      access("sw22", SW, 32'd22, 32'hDEADBEEF, 32'd0, 1'b0);
      access("lw22", LW, 32'd22, 32'd0, 32'hDEADBEEF, 1'b0);

      // back-to-back with req_valid held high
      @(negedge clk);
      req_valid = 1'b1;
      instr_id  = SW;
      addr      = 32'd110;
      wdata     = 32'd7;
      @(posedge clk);
      #1;
      addr  = 32'd111;
      wdata = 32'd9;
      low = 0;
      resp_seen = 0;
      @(negedge clk);
      while (!req_ready && low < 20) begin
         low++;
         if (resp_valid) resp_seen++;
         @(negedge clk);
      end
      chk("hs_ready_low", low, LAT + 2);
      chk("hs_first_resp", resp_seen, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_resp("hs2", rd, ft);
      chk("hs2_fault", {31'd0, ft}, 32'd0);
      access("lw110", LW, 32'd110, 32'd0, 32'd7, 1'b0);
      access("lw111", LW, 32'd111, 32'd0, 32'd9, 1'b0);

      // faults keep rdata and leave memory alone
      access("lw256", LW, 32'd256, 32'd0, 32'd9, 1'b1);
      access("swmax", SW, 32'hFFFFFFFF, 32'h0000AAAA, 32'd9, 1'b1);
      access("sw256", SW, 32'd256, 32'h0000BBBB, 32'd9, 1'b1);
      access("lw0", LW, 32'd0, 32'd0, 32'd0, 1'b0);
      access("lw255", LW, 32'd255, 32'd0, 32'd0, 1'b0);
      access("lw22b", LW, 32'd22, 32'd0, 32'hDEADBEEF, 1'b0);
      access("id5", 32'd5, 32'd23, 32'h00000055, 32'hDEADBEEF, 1'b1);
      access("lw23", LW, 32'd23, 32'd0, 32'd0, 1'b0);

`ifdef DATA_MEMORY_STAGE_STATS_EN
      l0 = load_count;
      s0 = store_count;
      f0 = fault_count;
      access("st_lw1", LW, 32'd110, 32'd0, 32'd7, 1'b0);
      access("st_lw2", LW, 32'd111, 32'd0, 32'd9, 1'b0);
      access("st_sw1", SW, 32'd60, 32'd3, 32'd9, 1'b0);
      access("st_lw3", LW, 32'd60, 32'd0, 32'd3, 1'b0);
      access("st_sw2", SW, 32'd61, 32'd4, 32'd3, 1'b0);
      access("st_flt", LW, 32'd300, 32'd0, 32'd3, 1'b1);
      chk("st_loads", {16'd0, 16'(load_count - l0)}, 32'd3);
      chk("st_stores", {16'd0, 16'(store_count - s0)}, 32'd2);
      chk("st_faults", {16'd0, 16'(fault_count - f0)}, 32'd1);
`endif

      // reset during WAIT discards the store
      issue(SW, 32'd40, 32'h00001234);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_busy", {31'd0, busy}, 32'd0);
      resp_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (resp_valid) resp_seen++;
      end
      reset = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (resp_valid) resp_seen++;
      end
      chk("mid_no_resp", resp_seen, 32'd0);
      access("lw40", LW, 32'd40, 32'd0, 32'd0, 1'b0);
      access("lw22c", LW, 32'd22, 32'd0, 32'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
